// File: rtl/result_reporter.sv
// ============================================================================
// Module   : result_reporter
// Purpose  : On the processor halt event, captures the self-check pass/fail
//            flags and the total cycle count. Streams them as ASCII characters
//            into the 64-character OLED display buffer through a ready/valid
//            write port. Flags are drawn as '+' or '-', and the count is drawn
//            as 8 uppercase hex digits.
// Options  : RESULT_REPORT_CLEAR_EN - when defined, the whole buffer is
//            blanked with spaces before the report is written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_reporter #(
   parameter int NUM_FLAGS  = 4,    // pass/fail flags shown (1..16)
   parameter int FLAG_BASE  = 0,    // buffer address of first flag character
   parameter int COUNT_BASE = 16    // buffer address of most-significant hex digit
) (
   input  logic                 sysclk,
   input  logic                 cpu_resetn,
   input  logic                 halt_i,
   input  logic [NUM_FLAGS-1:0] flags_i,
   input  logic [31:0]          count_i,
   input  logic                 wr_ready_i,
   output logic                 we_o,
   output logic [5:0]           waddr_o,
   output logic [7:0]           wdata_o,
   output logic                 busy_o,
   output logic                 done_o
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [5:0] c_flag_base   = 6'(FLAG_BASE);
   localparam logic [5:0] c_count_base  = 6'(COUNT_BASE);
   localparam logic [5:0] c_last_flag   = 6'(NUM_FLAGS - 1);
   localparam logic [5:0] c_last_nibble = 6'd7;
   localparam logic [5:0] c_last_addr   = 6'd63;
   localparam logic [7:0] c_blank       = 8'h20;   // ' '
   localparam logic [7:0] c_plus        = 8'h2B;   // '+'
   localparam logic [7:0] c_minus       = 8'h2D;   // '-'

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FLAGS = 3'd2,
      ST_COUNT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t               r_state;
   logic [5:0]           r_idx;      // position within the current region
   logic [NUM_FLAGS-1:0] r_flags;    // flags frozen at halt
   logic [31:0]          r_count;    // cycle count frozen at halt
   logic                 r_we;
   logic [5:0]           r_waddr;
   logic [7:0]           r_wdata;
   logic                 r_busy;
   logic                 r_done;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic       w_accept;
   logic [5:0] w_idx_nxt;

   assign w_accept  = r_we & wr_ready_i;
   assign w_idx_nxt = r_idx + 6'd1;

   // Character for flag k: '+' when the check passed, '-' otherwise.
   function automatic logic [7:0] flag_char(input logic [NUM_FLAGS-1:0] f,
                                            input logic [5:0]           k);
      logic [NUM_FLAGS-1:0] mask;
      mask = NUM_FLAGS'(1) << k;
      return (|(f & mask)) ? c_plus : c_minus;
   endfunction

   // Uppercase ASCII hex digit for a nibble.
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Hex digit at position pos of the count, position 0 being the MS nibble.
   function automatic logic [7:0] count_char(input logic [31:0] c,
                                             input logic [2:0]  pos);
      logic [31:0] sh;
      sh = c << {pos, 2'b00};
      return hex_char(sh[31:28]);
   endfunction

   // ------------------------------------------------------------------------
   // Report sequencer: capture on halt, then stream characters one accepted
   // write at a time. Every output is a register; a stalled write keeps
   // we/addr/data untouched because nothing advances without an accept.
   // ------------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         r_state <= ST_IDLE;
         r_idx   <= 6'd0;
         r_flags <= '0;
         r_count <= 32'd0;
         r_we    <= 1'b0;
         r_waddr <= 6'd0;
         r_wdata <= 8'h00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (halt_i) begin
                  // Freeze the results and present the first write next cycle.
                  r_flags <= flags_i;
                  r_count <= count_i;
                  r_idx   <= 6'd0;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
`ifdef RESULT_REPORT_CLEAR_EN
                  r_state <= ST_CLEAR;
                  r_waddr <= 6'd0;
                  r_wdata <= c_blank;
`else
                  // Flag 0 comes straight from the input being captured now.
                  r_state <= ST_FLAGS;
                  r_waddr <= c_flag_base;
                  r_wdata <= flag_char(flags_i, 6'd0);
`endif
               end
            end

`ifdef RESULT_REPORT_CLEAR_EN
            ST_CLEAR: begin
               if (w_accept) begin
                  if (r_idx == c_last_addr) begin
                     r_state <= ST_FLAGS;
                     r_idx   <= 6'd0;
                     r_waddr <= c_flag_base;
                     r_wdata <= flag_char(r_flags, 6'd0);
                  end else begin
                     r_idx   <= w_idx_nxt;
                     r_waddr <= w_idx_nxt;
                     r_wdata <= c_blank;
                  end
               end
            end
`endif

            ST_FLAGS: begin
               if (w_accept) begin
                  if (r_idx == c_last_flag) begin
                     r_state <= ST_COUNT;
                     r_idx   <= 6'd0;
                     r_waddr <= c_count_base;
                     r_wdata <= count_char(r_count, 3'd0);
                  end else begin
                     // Address wraps modulo 64 by construction.
                     r_idx   <= w_idx_nxt;
                     r_waddr <= c_flag_base + w_idx_nxt;
                     r_wdata <= flag_char(r_flags, w_idx_nxt);
                  end
               end
            end

            ST_COUNT: begin
               if (w_accept) begin
                  if (r_idx == c_last_nibble) begin
                     // Final accept: drop the request and flag completion together.
                     r_state <= ST_DONE;
                     r_idx   <= 6'd0;
                     r_we    <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= w_idx_nxt;
                     r_waddr <= c_count_base + w_idx_nxt;
                     r_wdata <= count_char(r_count, w_idx_nxt[2:0]);
                  end
               end
            end

            ST_DONE: begin
               // Only a low halt re-arms; a halt held high never retriggers.
               if (!halt_i) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_idx   <= 6'd0;
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign we_o    = r_we;
   assign waddr_o = r_waddr;
   assign wdata_o = r_wdata;
   assign busy_o  = r_busy;
   assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_result_reporter.sv
// ============================================================================
// Module   : tb_result_reporter
// Purpose  : Directed self-checking bench for result_reporter. A display-side
//            monitor records accepted writes into a 64-entry buffer image.
//            Works with or without RESULT_REPORT_CLEAR_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_reporter;

`ifdef RESULT_REPORT_CLEAR_EN
   localparam int       EXP_WRITES = 76;
   localparam bit       CLR        = 1'b1;
`else
   localparam int       EXP_WRITES = 12;
   localparam bit       CLR        = 1'b0;
`endif
   localparam logic [7:0] UNTOUCHED = 8'hAA;

   logic        sysclk = 1'b0;
   logic        cpu_resetn;
   logic        halt_i;
   logic [3:0]  flags_i;
   logic [31:0] count_i;
   logic        wr_ready_i;
   logic        we_o;
   logic [5:0]  waddr_o;
   logic [7:0]  wdata_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   // Display buffer image and write statistics, owned by the monitor only.
   logic [7:0] mem [64] = '{default: 8'hAA};
   int         n_acc = 0;
   int         n63   = 0;

   result_reporter dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .halt_i     (halt_i),
      .flags_i    (flags_i),
      .count_i    (count_i),
      .wr_ready_i (wr_ready_i),
      .we_o       (we_o),
      .waddr_o    (waddr_o),
      .wdata_o    (wdata_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 sysclk = ~sysclk;

   // Display side: take every accepted write into the buffer image.
   always @(posedge sysclk) begin
      if (we_o && wr_ready_i) begin
         mem[waddr_o] <= wdata_o;
         n_acc        <= n_acc + 1;
         if (waddr_o == 6'd63) n63 <= n63 + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Four flag characters expected at addresses 0..3, first char in MSB.
   task automatic check_flags(input string tag, input logic [31:0] s);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_flag%0d", tag, i), {24'h0, mem[i]}, {24'h0, s[31-8*i -: 8]});
   endtask

   // Eight hex characters expected at addresses 16..23, first char in MSB.
   task automatic check_count(input string tag, input logic [63:0] s);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_cnt%0d", tag, i), {24'h0, mem[16+i]}, {24'h0, s[63-8*i -: 8]});
   endtask

   // Full report with ready held high; inputs are disturbed after capture.
   task automatic run_report(input string tag, input logic [3:0] f, input logic [31:0] c);
      int n0;
      int cyc;
      n0         = n_acc;
      wr_ready_i = 1'b1;
      flags_i    = f;
      count_i    = c;
      halt_i     = 1'b1;
      @(negedge sysclk);
      cyc = 1;
      check({tag, "_first_we"},   {31'h0, we_o},   32'd1);
      check({tag, "_first_busy"}, {31'h0, busy_o}, 32'd1);
      check({tag, "_first_addr"}, {26'h0, waddr_o}, 32'd0);
      check({tag, "_first_data"}, {24'h0, wdata_o},
            CLR ? 32'h20 : (f[0] ? 32'h2B : 32'h2D));
      flags_i = ~f;
      count_i = ~c;
      while (!done_o && cyc < 300) begin
         @(negedge sysclk);
         cyc++;
      end
      check({tag, "_done_cycle"}, cyc, EXP_WRITES + 1);
      check({tag, "_writes"},     n_acc - n0, EXP_WRITES);
      check({tag, "_we_low"},     {31'h0, we_o},   32'd0);
      check({tag, "_busy_low"},   {31'h0, busy_o}, 32'd0);
   endtask

   task automatic rearm(input string tag);
      halt_i = 1'b0;
      @(negedge sysclk);
      @(negedge sysclk);
      check({tag, "_rearm_done"}, {31'h0, done_o}, 32'd0);
   endtask

   initial begin
      int n0;
      int n1;
      int guard;
      bit found;

      cpu_resetn = 1'b0;
      halt_i     = 1'b0;
      flags_i    = 4'h0;
      count_i    = 32'h0;
      wr_ready_i = 1'b1;
      repeat (2) @(negedge sysclk);

      // Reset state
      check("rst_we",    {31'h0, we_o},    32'd0);
      check("rst_busy",  {31'h0, busy_o},  32'd0);
      check("rst_done",  {31'h0, done_o},  32'd0);
      check("rst_waddr", {26'h0, waddr_o}, 32'd0);
      check("rst_wdata", {24'h0, wdata_o}, 32'd0);
      cpu_resetn = 1'b1;
      repeat (2) @(negedge sysclk);
      check("idle_we", {31'h0, we_o}, 32'd0);

      // All flags pass, small count
      run_report("t1", 4'b1111, 32'h0000_1A2F);
      check_flags("t1", "++++");
      check_count("t1", "00001A2F");
      check("t1_addr63", {24'h0, mem[63]}, CLR ? 32'h20 : {24'h0, UNTOUCHED});
      check("t1_addr40", {24'h0, mem[40]}, CLR ? 32'h20 : {24'h0, UNTOUCHED});
      check("t1_n63",    n63, CLR ? 1 : 0);
      // Halt held high in DONE: no retrigger, done stays up
      n0 = n_acc;
      repeat (4) @(negedge sysclk);
      check("t1_hold_done",   {31'h0, done_o}, 32'd1);
      check("t1_hold_writes", n_acc - n0, 0);
      check("t1_hold_we",     {31'h0, we_o}, 32'd0);
      rearm("t1");

      // Mixed flags, letters in the count (inputs disturbed after capture)
      run_report("t2", 4'b0101, 32'hDEAD_BEEF);
      check_flags("t2", "+-+-");
      check_count("t2", "DEADBEEF");
      rearm("t2");

      // Stalls during FLAGS: ready 1,0,0,1
      n0         = n_acc;
      wr_ready_i = 1'b1;
      flags_i    = 4'b0110;
      count_i    = 32'h0123_4567;
      halt_i     = 1'b1;
      found      = 1'b0;
      guard      = 0;
      while (!found && guard < 200) begin
         @(negedge sysclk);
         guard++;
         if (we_o && (wdata_o == 8'h2B || wdata_o == 8'h2D)) found = 1'b1;
      end
      check("t3_reach_flags", {31'h0, found}, 32'd1);
      check("t3_f0_addr", {26'h0, waddr_o}, 32'd0);
      check("t3_f0_data", {24'h0, wdata_o}, 32'h2D);
      wr_ready_i = 1'b1;
      @(negedge sysclk);
      check("t3_f1_addr", {26'h0, waddr_o}, 32'd1);
      check("t3_f1_data", {24'h0, wdata_o}, 32'h2B);
      wr_ready_i = 1'b0;
      for (int s = 0; s < 2; s++) begin
         @(negedge sysclk);
         check($sformatf("t3_stall%0d_we", s),   {31'h0, we_o},    32'd1);
         check($sformatf("t3_stall%0d_addr", s), {26'h0, waddr_o}, 32'd1);
         check($sformatf("t3_stall%0d_data", s), {24'h0, wdata_o}, 32'h2B);
      end
      wr_ready_i = 1'b1;
      guard = 0;
      while (!done_o && guard < 300) begin
         @(negedge sysclk);
         guard++;
      end
      check("t3_done",   {31'h0, done_o}, 32'd1);
      check("t3_writes", n_acc - n0, EXP_WRITES);
      check_flags("t3", "-++-");
      check_count("t3", "01234567");
      rearm("t3");

      // Asynchronous reset while in COUNT
      n0         = n_acc;
      wr_ready_i = 1'b1;
      flags_i    = 4'b1111;
      count_i    = 32'h0000_0000;
      halt_i     = 1'b1;
      found      = 1'b0;
      guard      = 0;
      while (!found && guard < 200) begin
         @(negedge sysclk);
         guard++;
         if (we_o && waddr_o == 6'd17 && wdata_o != 8'h20) found = 1'b1;
      end
      check("t5_reach_count", {31'h0, found}, 32'd1);
      check("t5_pre_writes",  n_acc - n0, EXP_WRITES - 7);
      #2 cpu_resetn = 1'b0;
      #1;
      check("t5_async_we",   {31'h0, we_o},   32'd0);
      check("t5_async_busy", {31'h0, busy_o}, 32'd0);
      check("t5_async_done", {31'h0, done_o}, 32'd0);
      halt_i = 1'b0;
      repeat (2) @(negedge sysclk);
      cpu_resetn = 1'b1;
      n1 = n_acc;
      repeat (5) @(negedge sysclk);
      check("t5_no_writes", n_acc - n1, 0);
      check("t5_idle_we",   {31'h0, we_o},   32'd0);
      check("t5_idle_busy", {31'h0, busy_o}, 32'd0);

      // Fresh report after the abort
      run_report("t6", 4'b1000, 32'hFFFF_0009);
      check_flags("t6", "---+");
      check_count("t6", "FFFF0009");
      check("t6_addr63", {24'h0, mem[63]}, CLR ? 32'h20 : {24'h0, UNTOUCHED});
      rearm("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
